// File: rtl/tsim_pkg.sv
// tsim_pkg: register offsets and FSM state type for the host control register block.
package tsim_pkg;
    typedef enum logic {IDLE, READ} state_t;
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_EVC     = 8'h04;
    localparam logic [7:0] REG_CONST   = 8'h08;
    localparam logic [7:0] REG_LEN     = 8'h0C;
    localparam logic [7:0] REG_INP_LO  = 8'h10;
    localparam logic [7:0] REG_INP_HI  = 8'h14;
    localparam logic [7:0] REG_OUT_LO  = 8'h18;
    localparam logic [7:0] REG_OUT_HI  = 8'h1C;
endpackage

// File: rtl/host_ctrl_regs.sv
// host_ctrl_regs: host-visible control/config registers that launch a compute stage
// and collect its finish flag and cycle count.
module host_ctrl_regs
    import tsim_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int MEM_ADDR_BITS  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      host_req_valid,
    input  logic                      host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
    input  logic [HOST_DATA_BITS-1:0] host_req_value,
    output logic                      host_req_deq,
    output logic                      host_resp_valid,
    output logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic                      launch,
    input  logic                      finish,
    input  logic                      event_counter_valid,
    input  logic [HOST_DATA_BITS-1:0] event_counter_value,
    output logic [HOST_DATA_BITS-1:0] constant,
    output logic [HOST_DATA_BITS-1:0] length,
    output logic [MEM_ADDR_BITS-1:0]  inp_baddr,
    output logic [MEM_ADDR_BITS-1:0]  out_baddr
);
    state_t                    r_state, w_state_nxt;
    logic                      w_deq, w_rd, w_wr;
    logic                      r_launch, r_finish;
    logic [HOST_DATA_BITS-1:0] r_evc, r_const, r_len, r_inp_lo, r_inp_hi, r_out_lo, r_out_hi;
    logic [HOST_DATA_BITS-1:0] r_resp, w_rdata;
    logic w_sel_ctrl, w_sel_evc, w_sel_const, w_sel_len;
    logic w_sel_inp_lo, w_sel_inp_hi, w_sel_out_lo, w_sel_out_hi;

    assign w_sel_ctrl   = host_req_addr == HOST_ADDR_BITS'(REG_CTRL);
    assign w_sel_evc    = host_req_addr == HOST_ADDR_BITS'(REG_EVC);
    assign w_sel_const  = host_req_addr == HOST_ADDR_BITS'(REG_CONST);
    assign w_sel_len    = host_req_addr == HOST_ADDR_BITS'(REG_LEN);
    assign w_sel_inp_lo = host_req_addr == HOST_ADDR_BITS'(REG_INP_LO);
    assign w_sel_inp_hi = host_req_addr == HOST_ADDR_BITS'(REG_INP_HI);
    assign w_sel_out_lo = host_req_addr == HOST_ADDR_BITS'(REG_OUT_LO);
    assign w_sel_out_hi = host_req_addr == HOST_ADDR_BITS'(REG_OUT_HI);

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_deq       = (r_state == IDLE) && host_req_valid;
        w_rd        = w_deq && !host_req_opcode;
        w_wr        = w_deq && host_req_opcode;
        w_state_nxt = w_rd ? READ : IDLE;
    end

    // Unmapped addresses fall through to zero but still get a response.
    always_comb begin
        w_rdata = w_sel_ctrl   ? {{(HOST_DATA_BITS-2){1'b0}}, r_finish, r_launch} :
                  w_sel_evc    ? r_evc    :
                  w_sel_const  ? r_const  :
                  w_sel_len    ? r_len    :
                  w_sel_inp_lo ? r_inp_lo :
                  w_sel_inp_hi ? r_inp_hi :
                  w_sel_out_lo ? r_out_lo :
                  w_sel_out_hi ? r_out_hi : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_launch <= 1'b0;
            r_finish <= 1'b0;
            r_evc    <= '0;
            r_const  <= '0;
            r_len    <= '0;
            r_inp_lo <= '0;
            r_inp_hi <= '0;
            r_out_lo <= '0;
            r_out_hi <= '0;
            r_resp   <= '0;
        end else begin
            if (w_rd) r_resp <= w_rdata;
            // The finish pulse takes priority over a coincident ctrl write for both bits.
            if (finish) begin
                r_launch <= 1'b0;
                r_finish <= 1'b1;
            end else if (w_wr && w_sel_ctrl) begin
                r_launch <= host_req_value[0];
                if (host_req_value[0]) r_finish <= 1'b0;
            end
            if (event_counter_valid)     r_evc <= event_counter_value;
            else if (w_wr && w_sel_evc)  r_evc <= host_req_value;
            if (w_wr && w_sel_const)  r_const  <= host_req_value;
            if (w_wr && w_sel_len)    r_len    <= host_req_value;
            if (w_wr && w_sel_inp_lo) r_inp_lo <= host_req_value;
            if (w_wr && w_sel_inp_hi) r_inp_hi <= host_req_value;
            if (w_wr && w_sel_out_lo) r_out_lo <= host_req_value;
            if (w_wr && w_sel_out_hi) r_out_hi <= host_req_value;
        end
    end

    // Gating with reset lets a reset in the READ cycle suppress the response.
    assign host_req_deq    = w_deq;
    assign host_resp_valid = (r_state == READ) && !reset;
    assign host_resp_bits  = r_resp;
    assign launch          = r_launch;
    assign constant        = r_const;
    assign length          = r_len;
    assign inp_baddr       = MEM_ADDR_BITS'({r_inp_hi, r_inp_lo});
    assign out_baddr       = MEM_ADDR_BITS'({r_out_hi, r_out_lo});
endmodule

// File: tb/tb_host_ctrl_regs.sv
// tb_host_ctrl_regs: scoreboard bench for host_ctrl_regs; expected read data is queued
// at request time and checked when the response appears.
module tb_host_ctrl_regs;
    logic        clock = 1'b0;
    logic        reset;
    logic        host_req_valid, host_req_opcode;
    logic [7:0]  host_req_addr;
    logic [31:0] host_req_value;
    logic        host_req_deq, host_resp_valid;
    logic [31:0] host_resp_bits;
    logic        launch, finish, event_counter_valid;
    logic [31:0] event_counter_value, constant, length;
    logic [63:0] inp_baddr, out_baddr;
    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    always #5 clock = ~clock;

    host_ctrl_regs dut (
        .clock(clock), .reset(reset),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .launch(launch), .finish(finish),
        .event_counter_valid(event_counter_valid), .event_counter_value(event_counter_value),
        .constant(constant), .length(length), .inp_baddr(inp_baddr), .out_baddr(out_baddr)
    );

    always @(negedge clock) begin
        if (host_resp_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got resp_valid=1 bits=%h, required no response", host_resp_bits);
            end else begin
                mon_exp = sb.pop_front();
                if (host_resp_bits !== mon_exp) begin
                    bad++;
                    $display("FAIL resp_bits: got %h, required %h", host_resp_bits, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [7:0] a, input logic [31:0] v);
        host_req_valid = 1'b1; host_req_opcode = 1'b1; host_req_addr = a; host_req_value = v;
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b1) begin bad++; $display("FAIL wr_deq @%h: got %b, required 1", a, host_req_deq); end
        @(posedge clock); #1;
        host_req_valid = 1'b0;
        @(negedge clock);
        total++;
        if (host_resp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_resp @%h: got %b, required 0", a, host_resp_valid); end
        @(posedge clock); #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp);
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = a;
        sb.push_back(exp);
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b1 || host_resp_valid !== 1'b0) begin
            bad++; $display("FAIL rd_deq @%h: got deq=%b resp=%b, required deq=1 resp=0", a, host_req_deq, host_resp_valid);
        end
        @(posedge clock); #1;
        host_req_valid = 1'b0;
        @(negedge clock); #1;
        total++;
        if (host_resp_valid !== 1'b1 || sb.size() != 0) begin
            bad++; $display("FAIL rd_resp_timing @%h: got resp=%b pending=%0d, required resp=1 pending=0", a, host_resp_valid, sb.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; host_req_valid = 1'b0; host_req_opcode = 1'b0; host_req_addr = '0;
        host_req_value = '0; finish = 1'b0; event_counter_valid = 1'b0; event_counter_value = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        total++;
        if ({host_req_deq, host_resp_valid, launch, host_resp_bits, constant, length, inp_baddr, out_baddr} !== '0) begin
            bad++; $display("FAIL reset_state: got deq=%b rv=%b launch=%b bits=%h const=%h len=%h inp=%h out=%h, required all 0",
                host_req_deq, host_resp_valid, launch, host_resp_bits, constant, length, inp_baddr, out_baddr);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_constant();
        do_write(8'h08, 32'd5);
        total++;
        if (constant !== 32'd5) begin bad++; $display("FAIL constant_out: got %h, required 5", constant); end
        do_read(8'h08, 32'd5);
        do_write(8'h0C, 32'd77);
        do_read(8'h0C, 32'd77);
    endtask

    task automatic test_baddr();
        do_write(8'h10, 32'h1000);
        do_write(8'h14, 32'h2);
        total++;
        if (inp_baddr !== 64'h0000_0002_0000_1000) begin bad++; $display("FAIL inp_baddr: got %h, required 0000000200001000", inp_baddr); end
        do_write(8'h18, 32'hCAFE_0000);
        do_write(8'h1C, 32'h8000_0001);
        total++;
        if (out_baddr !== 64'h8000_0001_CAFE_0000) begin bad++; $display("FAIL out_baddr: got %h, required 80000001cafe0000", out_baddr); end
        do_read(8'h14, 32'h2);
        do_read(8'h18, 32'hCAFE_0000);
    endtask

    task automatic test_launch_finish();
        do_write(8'h00, 32'h1);
        total++;
        if (launch !== 1'b1) begin bad++; $display("FAIL launch_set: got %b, required 1", launch); end
        do_write(8'h0C, 32'd123);
        total++;
        if (length !== 32'd123 || launch !== 1'b1) begin bad++; $display("FAIL cfg_while_launch: got len=%0d launch=%b, required 123/1", length, launch); end
        finish = 1'b1;
        @(posedge clock); #1 finish = 1'b0;
        total++;
        if (launch !== 1'b0) begin bad++; $display("FAIL launch_clear: got %b, required 0", launch); end
        do_read(8'h00, 32'h2);
        do_write(8'h00, 32'h3);
        do_read(8'h00, 32'h1);
        do_write(8'h00, 32'h0);
        do_read(8'h00, 32'h0);
    endtask

    task automatic test_finish_collision();
        finish = 1'b1;
        do_write(8'h00, 32'h1);
        finish = 1'b0;
        total++;
        if (launch !== 1'b0) begin bad++; $display("FAIL collide_launch: got %b, required 0", launch); end
        do_read(8'h00, 32'h2);
    endtask

    task automatic test_event_counter();
        event_counter_valid = 1'b1; event_counter_value = 32'd42;
        @(posedge clock); #1 event_counter_valid = 1'b0;
        do_read(8'h04, 32'd42);
        do_read(8'h24, 32'd0);
        do_write(8'h24, 32'hDEAD_BEEF);
        do_read(8'h24, 32'd0);
        do_read(8'h09, 32'd0);
        event_counter_valid = 1'b1; event_counter_value = 32'd99;
        do_write(8'h04, 32'd7);
        event_counter_valid = 1'b0;
        do_read(8'h04, 32'd99);
        do_write(8'h04, 32'd7);
        do_read(8'h04, 32'd7);
    endtask

    task automatic test_back_to_back();
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h08;
        sb.push_back(32'd5);
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b1) begin bad++; $display("FAIL b2b_deq1: got %b, required 1", host_req_deq); end
        @(posedge clock); #1 host_req_addr = 8'h0C;
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b0) begin bad++; $display("FAIL b2b_no_deq_in_read: got %b, required 0", host_req_deq); end
        @(posedge clock); #1;
        sb.push_back(32'd123);
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b1) begin bad++; $display("FAIL b2b_deq2: got %b, required 1", host_req_deq); end
        @(posedge clock); #1 host_req_valid = 1'b0;
        @(negedge clock); #1;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d, required 0", sb.size()); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_in_read();
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h08;
        @(negedge clock);
        total++;
        if (host_req_deq !== 1'b1) begin bad++; $display("FAIL rst_read_deq: got %b, required 1", host_req_deq); end
        @(posedge clock); #1;
        host_req_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        total++;
        if (host_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_read_resp: got %b, required 0", host_resp_valid); end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        total++;
        if ({host_resp_valid, launch, host_resp_bits, constant, length, inp_baddr, out_baddr} !== '0) begin
            bad++; $display("FAIL rst_read_outputs: got rv=%b launch=%b bits=%h const=%h len=%h inp=%h out=%h, required all 0",
                host_resp_valid, launch, host_resp_bits, constant, length, inp_baddr, out_baddr);
        end
        @(posedge clock); #1;
        do_read(8'h00, 32'h0);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_baddr();
        test_launch_finish();
        test_finish_collision();
        test_event_counter();
        test_back_to_back();
        test_reset_in_read();
        repeat (2) @(posedge clock);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
